mac_ctrl: RTL and testbench

MAC_CTRL -- requirements
Module: mac_ctrl

---
 rtl/mac_ctrl.sv | 128 ++++++++++++
 tb/tb_mac_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_ctrl.sv
// Sequencer for a 4-cycle bit-serial MAC: accepts an activation vector, runs the datapath, waits out its latency, holds the result.
// Define MAC_CTRL_PERF_EN to add the perf_cnt completed-operation counter.
module mac_ctrl #(
  parameter int RESULT_LAT = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0][3:0]      in_xin,
  output logic                  mac_en,
  output logic                  mac_clr,
  output logic [15:0][3:0]      mac_xin,
  input  logic [13:0]           mac_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [13:0]           out_result,
  output logic                  busy
`ifdef MAC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]      perf_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT, OUT} state_t;

  // The last RUN cycle already counts as the first latency cycle, so WAIT lasts RESULT_LAT-1 cycles.
  localparam logic [2:0] LAT_LAST = 3'((RESULT_LAT > 1) ? (RESULT_LAT - 2) : 0);

  state_t      state, state_d;
  logic [1:0]  bit_cnt, bit_cnt_d;
  logic [2:0]  lat_cnt, lat_cnt_d;
  logic        accept, capture, abort_clr;

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    lat_cnt_d = lat_cnt;
    accept    = 1'b0;
    capture   = 1'b0;
    abort_clr = 1'b0;
    case (state)
      IDLE: begin
        if (!clear && in_valid) begin
          accept    = 1'b1;
          bit_cnt_d = 2'd0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (clear) begin
          abort_clr = 1'b1;
          state_d   = IDLE;
        end else if (bit_cnt == 2'd3) begin
          lat_cnt_d = 3'd0;
          if (RESULT_LAT == 1) begin
            capture = 1'b1;
            state_d = OUT;
          end else begin
            state_d = WAIT;
          end
        end else begin
          bit_cnt_d = bit_cnt + 2'd1;
        end
      end
      WAIT: begin
        if (clear) begin
          abort_clr = 1'b1;
          state_d   = IDLE;
        end else if (lat_cnt == LAT_LAST) begin
          capture = 1'b1;
          state_d = OUT;
        end else begin
          lat_cnt_d = lat_cnt + 3'd1;
        end
      end
      OUT: begin
        if (clear || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= 2'd0;
      lat_cnt <= 3'd0;
      mac_clr <= 1'b0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      lat_cnt <= lat_cnt_d;
      mac_clr <= abort_clr;
    end
  end

  // Operand and result holding registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_xin    <= '0;
      out_result <= '0;
    end else begin
      if (accept)  mac_xin    <= in_xin;
      if (capture) out_result <= mac_result;
    end
  end

`ifdef MAC_CTRL_PERF_EN
  logic handshake;
  assign handshake = (state == OUT) && out_ready && !clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           perf_cnt <= '0;
    else if (handshake) perf_cnt <= perf_cnt + 1'b1;
  end
`endif

  // in_ready is gated by reset itself so it reads 0 while rst is held low.
  assign in_ready  = (state == IDLE) && rst;
  assign mac_en    = (state == RUN);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mac_ctrl.sv
// Directed self-checking bench for mac_ctrl (RESULT_LAT=2, CNT_W=4).
module tb_mac_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, clear, in_valid, out_ready;
  logic             in_ready, mac_en, mac_clr, out_valid, busy;
  logic [15:0][3:0] in_xin, mac_xin;
  logic [13:0]      mac_result, out_result;
`ifdef MAC_CTRL_PERF_EN
  logic [3:0]       perf_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int perf_exp = 0;
  logic [15:0][3:0] xin_a, xin_b, xin_f;

  mac_ctrl #(.RESULT_LAT(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_xin(in_xin),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_xin(mac_xin),
    .mac_result(mac_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .busy(busy)
`ifdef MAC_CTRL_PERF_EN
    , .perf_cnt(perf_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_xin = xin_f; mac_result = 14'h1234;
    #12;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (mac_en !== 1'b0 || mac_clr !== 1'b0) begin failures++; $display("FAIL reset_mac_ctl got en=%b clr=%b want 0 0", mac_en, mac_clr); end
    checks++; if (mac_xin !== '0) begin failures++; $display("FAIL reset_mac_xin got %h want 0", mac_xin); end
    checks++; if (out_valid !== 1'b0 || out_result !== 14'd0 || busy !== 1'b0) begin failures++; $display("FAIL reset_out got v=%b r=%h busy=%b want 0 0 0", out_valid, out_result, busy); end
`ifdef MAC_CTRL_PERF_EN
    checks++; if (perf_cnt !== 4'd0) begin failures++; $display("FAIL reset_perf got %0d want 0", perf_cnt); end
`endif
    @(negedge clk); rst = 1'b1;
    tick;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
  endtask

  // Accept at cycle 0, mac_en cycles 1-4, capture during cycle 5, out_valid from cycle 6.
  task automatic test_basic;
    in_xin = xin_f; in_valid = 1'b1; mac_result = 14'd200;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_c0_in_ready got %b want 1", in_ready); end
    for (int c = 1; c <= 6; c++) begin
      tick;
      in_xin = xin_a;
      mac_result = 14'(200 + c);
      checks++; if (mac_en !== (c <= 4)) begin failures++; $display("FAIL basic_mac_en c%0d got %b want %b", c, mac_en, (c <= 4)); end
      checks++; if (out_valid !== (c == 6)) begin failures++; $display("FAIL basic_out_valid c%0d got %b want %b", c, out_valid, (c == 6)); end
      checks++; if (in_ready !== 1'b0 || mac_xin !== xin_f) begin failures++; $display("FAIL basic_hold c%0d got rdy=%b xin=%h want 0 %h", c, in_ready, mac_xin, xin_f); end
    end
    checks++; if (out_result !== 14'd205) begin failures++; $display("FAIL basic_result got %0d want 205", out_result); end
  endtask

  task automatic test_hold;
    for (int c = 0; c < 10; c++) begin
      tick;
      mac_result = 14'($urandom_range(0, 16383));
      in_xin = xin_b;
      checks++; if (out_valid !== 1'b1 || out_result !== 14'd205) begin failures++; $display("FAIL hold_out c%0d got v=%b r=%0d want 1 205", c, out_valid, out_result); end
      checks++; if (in_ready !== 1'b0 || mac_xin !== xin_f || mac_en !== 1'b0) begin failures++; $display("FAIL hold_ctl c%0d got rdy=%b en=%b xin=%h", c, in_ready, mac_en, mac_xin); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    perf_exp = (perf_exp + 1) % 16;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL hold_release got v=%b rdy=%b want 0 1", out_valid, in_ready); end
`ifdef MAC_CTRL_PERF_EN
    checks++; if (perf_cnt !== 4'(perf_exp)) begin failures++; $display("FAIL hold_perf got %0d want %0d", perf_cnt, perf_exp); end
`endif
  endtask

  task automatic test_clear_run_wait;
    in_xin = xin_a; in_valid = 1'b1;
    tick; in_valid = 1'b0;
    tick; tick;
    checks++; if (mac_en !== 1'b1) begin failures++; $display("FAIL clrrun_c3_en got %b want 1", mac_en); end
    clear = 1'b1;
    tick; clear = 1'b0;
    checks++; if (mac_en !== 1'b0 || mac_clr !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL clrrun_pulse got en=%b clr=%b v=%b want 0 1 0", mac_en, mac_clr, out_valid); end
    tick;
    checks++; if (mac_clr !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL clrrun_idle got clr=%b rdy=%b busy=%b v=%b want 0 1 0 0", mac_clr, in_ready, busy, out_valid); end
    checks++; if (out_result !== 14'd205) begin failures++; $display("FAIL clrrun_result got %0d want 205", out_result); end
    in_valid = 1'b1;
    tick; in_valid = 1'b0;
    tick; tick; tick; tick;
    checks++; if (busy !== 1'b1 || mac_en !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL clrwait_state got busy=%b en=%b v=%b want 1 0 0", busy, mac_en, out_valid); end
    mac_result = 14'h3FF; clear = 1'b1;
    tick; clear = 1'b0;
    checks++; if (mac_clr !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL clrwait_pulse got clr=%b v=%b rdy=%b want 1 0 1", mac_clr, out_valid, in_ready); end
    tick;
    checks++; if (mac_clr !== 1'b0 || out_result !== 14'd205 || mac_xin !== xin_a) begin failures++; $display("FAIL clrwait_after got clr=%b r=%0d want 0 205", mac_clr, out_result); end
  endtask

  task automatic test_clear_idle;
    clear = 1'b1; in_valid = 1'b1; in_xin = xin_b;
    tick;
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || mac_en !== 1'b0 || mac_clr !== 1'b0) begin failures++; $display("FAIL clridle_state got rdy=%b busy=%b en=%b clr=%b want 1 0 0 0", in_ready, busy, mac_en, mac_clr); end
    checks++; if (mac_xin !== xin_a) begin failures++; $display("FAIL clridle_xin got %h want %h", mac_xin, xin_a); end
  endtask

  task automatic test_clear_out;
    in_xin = xin_b; in_valid = 1'b1; mac_result = 14'd77;
    tick; in_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick;
    checks++; if (out_valid !== 1'b1 || out_result !== 14'd77 || mac_xin !== xin_b) begin failures++; $display("FAIL clrout_result got v=%b r=%0d want 1 77", out_valid, out_result); end
    out_ready = 1'b1; clear = 1'b1;
    tick;
    out_ready = 1'b0; clear = 1'b0;
    checks++; if (out_valid !== 1'b0 || mac_clr !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL clrout_abort got v=%b clr=%b rdy=%b want 0 0 1", out_valid, mac_clr, in_ready); end
`ifdef MAC_CTRL_PERF_EN
    checks++; if (perf_cnt !== 4'(perf_exp)) begin failures++; $display("FAIL clrout_perf got %0d want %0d", perf_cnt, perf_exp); end
`endif
  endtask

  task automatic test_reset_mid;
    in_xin = xin_a; in_valid = 1'b1; mac_result = 14'd55;
    tick; in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick;
    checks++; if (busy !== 1'b1 || mac_en !== 1'b0) begin failures++; $display("FAIL rstmid_wait got busy=%b en=%b want 1 0", busy, mac_en); end
    #2 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || mac_en !== 1'b0 || mac_clr !== 1'b0) begin failures++; $display("FAIL rstmid_ctl got busy=%b rdy=%b en=%b clr=%b want 0 0 0 0", busy, in_ready, mac_en, mac_clr); end
    checks++; if (mac_xin !== '0 || out_result !== 14'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_data got xin=%h r=%0d v=%b want 0 0 0", mac_xin, out_result, out_valid); end
    perf_exp = 0;
`ifdef MAC_CTRL_PERF_EN
    checks++; if (perf_cnt !== 4'd0) begin failures++; $display("FAIL rstmid_perf got %0d want 0", perf_cnt); end
`endif
    @(negedge clk); rst = 1'b1;
    tick;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_release got %b want 1", in_ready); end
    in_xin = xin_b; in_valid = 1'b1; mac_result = 14'd321;
    tick; in_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick;
    checks++; if (out_valid !== 1'b1 || out_result !== 14'd321 || mac_xin !== xin_b) begin failures++; $display("FAIL rstmid_op got v=%b r=%0d want 1 321", out_valid, out_result); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    perf_exp = (perf_exp + 1) % 16;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_done got v=%b rdy=%b want 0 1", out_valid, in_ready); end
  endtask

`ifdef MAC_CTRL_PERF_EN
  task automatic test_perf;
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      in_xin = xin_a; in_valid = 1'b1; mac_result = 14'(k + 1000);
      tick; in_valid = 1'b0;
      for (int n = 0; n < 20 && !out_valid; n++) tick;
      checks++; if (out_valid !== 1'b1 || out_result !== 14'(k + 1000)) begin failures++; $display("FAIL perf_op%0d got v=%b r=%0d want 1 %0d", k, out_valid, out_result, k + 1000); end
      tick;
      perf_exp = (perf_exp + 1) % 16;
      checks++; if (perf_cnt !== 4'(perf_exp)) begin failures++; $display("FAIL perf_cnt op%0d got %0d want %0d", k, perf_cnt, perf_exp); end
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    tick; in_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick;
    clear = 1'b1; out_ready = 1'b1;
    tick;
    clear = 1'b0; out_ready = 1'b0;
    checks++; if (perf_cnt !== 4'(perf_exp) || out_valid !== 1'b0) begin failures++; $display("FAIL perf_clear_out got cnt=%0d v=%b want %0d 0", perf_cnt, out_valid, perf_exp); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) begin
      xin_a[i] = 4'(i);
      xin_b[i] = 4'(15 - i) ^ 4'h5;
    end
    xin_f = '1;
    test_reset;
    test_basic;
    test_hold;
    test_clear_run_wait;
    test_clear_idle;
    test_clear_out;
    test_reset_mid;
`ifdef MAC_CTRL_PERF_EN
    test_perf;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
